conv_encoder_stream: RTL

Parametrised streaming convolutional encoder, the next generation of the codec's encoder path. It accepts one DATA_W-bit frame per valid/ready handshake and encodes BPC bits per cycle. Constraint length and code rate are runtime-selectable. Encoder state is carried across frames or loaded externally, and tail termination is optional. The coded frame, tail bits and final state are returned through an output valid/ready handshake.

---
 rtl/conv_encoder_stream.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/conv_encoder_stream.sv
// conv_encoder_stream
//   Streaming convolutional encoder. One DATA_W-bit frame is accepted per
//   valid/ready handshake, encoded BPC bits per clock with a runtime-selected
//   constraint length K (3..MAX_K) and rate 1/2 or 1/3, optionally terminated
//   with K-1 zero tail bits, and returned through an output valid/ready
//   handshake together with the state reached after the last data bit.
//
// Ports
//   sys_clk              clock
//   rst                  synchronous reset, active-low
//   i_cfg_k              constraint length K
//   i_code_rate          0 = rate 1/2, 1 = rate 1/3
//   i_gen_poly_flat      generator j at [j*MAX_K +: MAX_K], bit 0 taps the input
//   i_term               append K-1 zero tail bits
//   i_state_load         start from i_prv_encoder_state instead of carried state
//   i_prv_encoder_state  external start state
//   i_valid / o_ready    input frame handshake
//   i_data               information bits, bit 0 encoded first
//   o_valid / i_ready    result handshake
//   o_data               densely packed coded frame
//   o_tail_data          densely packed coded tail
//   o_final_state        state after the last data bit
//   o_err                illegal K for the presented frame
//   o_busy               frame in progress
module conv_encoder_stream #(
    parameter int DATA_W = 128,
    parameter int BPC    = 8,
    parameter int MAX_K  = 9,
    parameter int MAX_N  = 3
) (
    input  logic                         sys_clk,
    input  logic                         rst,
    input  logic [3:0]                   i_cfg_k,
    input  logic                         i_code_rate,
    input  logic [MAX_K*MAX_N-1:0]       i_gen_poly_flat,
    input  logic                         i_term,
    input  logic                         i_state_load,
    input  logic [MAX_K-2:0]             i_prv_encoder_state,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [DATA_W-1:0]            i_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [DATA_W*MAX_N-1:0]      o_data,
    output logic [(MAX_K-1)*MAX_N-1:0]   o_tail_data,
    output logic [MAX_K-2:0]             o_final_state,
    output logic                         o_err,
    output logic                         o_busy
);

    localparam int CYCLES = DATA_W / BPC;
    localparam int CNT_W  = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam int SW     = MAX_K - 1;
    localparam int CW     = DATA_W * MAX_N;
    localparam int TW     = SW * MAX_N;
    localparam int KW     = BPC * MAX_N;

    typedef enum logic [1:0] {IDLE, ENC, TAIL, DONE} state_t;

    state_t state, state_next;

    logic [CNT_W-1:0]       cnt;
    logic [SW-1:0]          carry;
    logic [DATA_W-1:0]      data_sr;
    logic [SW-1:0]          enc_state;
    logic [CW-1:0]          coded_raw;
    logic [TW-1:0]          tail_raw;
    logic [3:0]             cfg_k;
    logic [MAX_K-1:0]       cfg_kmask;
    logic                   cfg_n3;
    logic [MAX_K*MAX_N-1:0] cfg_gen;
    logic                   cfg_term;
    logic                   cfg_err;

    logic [MAX_K-1:0]       in_kmask;
    logic [SW-1:0]          start_state;
    logic [SW-1:0]          s_walk;
    logic [KW-1:0]          chunk;
    logic [SW-1:0]          t_walk;
    logic [TW-1:0]          tail_chunk;

    // Ones in bits 0..K-1; K above MAX_K saturates, K=0 gives an empty mask.
    function automatic logic [MAX_K-1:0] k_mask(input logic [3:0] k);
        logic [MAX_K-1:0] m;
        m = '0;
        for (int b = 0; b < MAX_K; b++) begin
            if (b < int'(k)) m[b] = 1'b1;
        end
        return m;
    endfunction

    // Coded bits for input u with state s; window bit 0 is u, bit m is s[m-1].
    function automatic logic [MAX_N-1:0] code_bit(input logic [SW-1:0] s, input logic u,
                                                  input logic [MAX_K-1:0] km,
                                                  input logic [MAX_K*MAX_N-1:0] g);
        logic [MAX_K-1:0] window;
        logic [MAX_N-1:0] c;
        window = {s, u} & km;
        for (int j = 0; j < MAX_N; j++) begin
            c[j] = ^(g[j*MAX_K +: MAX_K] & window);
        end
        return c;
    endfunction

    function automatic logic [SW-1:0] shift_state(input logic [SW-1:0] s, input logic u,
                                                  input logic [MAX_K-1:0] km);
        return {s[SW-2:0], u} & km[MAX_K-1:1];
    endfunction

    // Raw buffers keep MAX_N slots per input bit; rate 1/2 drops the third slot.
    function automatic logic [CW-1:0] pack_data(input logic [CW-1:0] raw, input logic n3);
        logic [CW-1:0] p;
        p = '0;
        for (int i = 0; i < DATA_W; i++) begin
            for (int j = 0; j < MAX_N; j++) begin
                if (n3) p[i*MAX_N+j] = raw[i*MAX_N+j];
                else if (j < 2) p[i*2+j] = raw[i*MAX_N+j];
            end
        end
        return p;
    endfunction

    function automatic logic [TW-1:0] pack_tail(input logic [TW-1:0] raw, input logic n3);
        logic [TW-1:0] p;
        p = '0;
        for (int i = 0; i < SW; i++) begin
            for (int j = 0; j < MAX_N; j++) begin
                if (n3) p[i*MAX_N+j] = raw[i*MAX_N+j];
                else if (j < 2) p[i*2+j] = raw[i*MAX_N+j];
            end
        end
        return p;
    endfunction

    always_comb begin
        in_kmask    = k_mask(i_cfg_k);
        start_state = (i_state_load ? i_prv_encoder_state : carry) & in_kmask[MAX_K-1:1];
    end

    // One ENC cycle: walk BPC bits through the encoder, bit 0 of the shifter first.
    always_comb begin
        s_walk = enc_state;
        chunk  = '0;
        for (int b = 0; b < BPC; b++) begin
            chunk[b*MAX_N +: MAX_N] = code_bit(s_walk, data_sr[b], cfg_kmask, cfg_gen);
            s_walk = shift_state(s_walk, data_sr[b], cfg_kmask);
        end
    end

    // Tail: K-1 zero inputs starting from the final data state.
    always_comb begin
        t_walk     = enc_state;
        tail_chunk = '0;
        for (int t = 0; t < SW; t++) begin
            if (t < int'(cfg_k) - 1) begin
                tail_chunk[t*MAX_N +: MAX_N] = code_bit(t_walk, 1'b0, cfg_kmask, cfg_gen);
                t_walk = shift_state(t_walk, 1'b0, cfg_kmask);
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        o_ready    = 1'b0;
        o_busy     = 1'b1;
        case (state)
            IDLE: begin
                o_ready = 1'b1;
                o_busy  = 1'b0;
                if (i_valid) state_next = ENC;
            end
            ENC:  if (cnt == CNT_W'(CYCLES - 1)) state_next = cfg_term ? TAIL : DONE;
            TAIL: state_next = DONE;
            // The first DONE cycle registers the result; release needs o_valid seen.
            DONE: if (o_valid && i_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            o_valid       <= 1'b0;
            o_err         <= 1'b0;
            o_data        <= '0;
            o_tail_data   <= '0;
            o_final_state <= '0;
            carry         <= '0;
            cnt           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        o_err <= 1'b0;
                        cnt   <= '0;
                    end
                end
                ENC: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(CYCLES - 1) && !cfg_err)
                        carry <= cfg_term ? '0 : s_walk;
                end
                DONE: begin
                    if (!o_valid) begin
                        o_valid       <= 1'b1;
                        o_err         <= cfg_err;
                        o_data        <= cfg_err ? '0 : pack_data(coded_raw, cfg_n3);
                        o_tail_data   <= cfg_err ? '0 : pack_tail(tail_raw, cfg_n3);
                        o_final_state <= cfg_err ? '0 : enc_state;
                    end else if (i_ready) begin
                        o_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Working registers: only meaningful between acceptance and DONE.
    always_ff @(posedge sys_clk) begin
        case (state)
            IDLE: begin
                if (i_valid) begin
                    data_sr   <= i_data;
                    cfg_k     <= i_cfg_k;
                    cfg_kmask <= in_kmask;
                    cfg_n3    <= i_code_rate;
                    cfg_gen   <= i_gen_poly_flat;
                    cfg_term  <= i_term;
                    cfg_err   <= (int'(i_cfg_k) < 3) || (int'(i_cfg_k) > MAX_K);
                    enc_state <= start_state;
                    tail_raw  <= '0;
                end
            end
            ENC: begin
                data_sr   <= data_sr >> BPC;
                enc_state <= s_walk;
                // Chunks enter at the top so chunk 0 ends at the bottom.
                coded_raw <= {chunk, coded_raw[CW-1:KW]};
            end
            TAIL: tail_raw <= tail_chunk;
            default: ;
        endcase
    end

endmodule
